// File: rtl/nn_inference_scheduler.sv
// Arbitrates manual and frame-driven compute requests for the neural network,
// handles the start/ready handshake with a timeout and reduces the probabilities to an argmax.
module nn_inference_scheduler #(
  parameter int NUM_CLASSES = 10,
  parameter int PROB_W      = 16,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int AUTO_EN     = 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Frame_vs,
  input  logic                          Key_req,
  input  logic                          Canvas_dirty,
  input  logic                          Nn_ready,
  input  logic [NUM_CLASSES*PROB_W-1:0] Nn_prob,
  output logic                          Nn_start,
  output logic                          Busy,
  output logic [3:0]                    Argmax,
  output logic [PROB_W-1:0]             Max_prob,
  output logic                          Result_valid,
  output logic                          Timeout_err
);

  localparam int   CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int   IDX_W   = 4;
  localparam logic AUTO_ON = (AUTO_EN != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         fvs_sync_q, key_sync_q;
  logic               key_pend_q, key_pend_d;
  logic               auto_pend_q, auto_pend_d;
  logic               dirty_q, dirty_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]   argmax_q, argmax_d;
  logic [PROB_W-1:0]  maxp_q, maxp_d;
  logic               terr_q, terr_d;
  logic [PROB_W-1:0]  best_val_q, best_val_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [PROB_W-1:0]  prob_q [NUM_CLASSES];
  logic               capture;
  logic               take;
  logic               frame_tick, key_tick;

  // Bits [1:0] are the 2-flop synchronizer; bit 2 holds the previous synchronized level.
  assign frame_tick = fvs_sync_q[1] & ~fvs_sync_q[2];
  assign key_tick   = key_sync_q[1] & ~key_sync_q[2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    scan_d     = scan_q;
    argmax_d   = argmax_q;
    maxp_d     = maxp_q;
    terr_d     = terr_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    capture    = 1'b0;
    take       = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_pend_q || auto_pend_q) begin
          take    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        ack_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!Nn_ready) ack_d = 1'b1;
        // A ready seen before the network has dropped it belongs to the previous run.
        if (Nn_ready && ack_q) begin
          capture    = 1'b1;
          best_val_d = Nn_prob[0 +: PROB_W];
          best_idx_d = '0;
          scan_d     = IDX_W'(1);
          state_d    = SCAN;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (prob_q[scan_q] > best_val_q) begin
          best_val_d = prob_q[scan_q];
          best_idx_d = scan_q;
        end
        scan_d = scan_q + 1'b1;
        if (scan_q == IDX_W'(NUM_CLASSES - 1)) begin
          argmax_d = best_idx_d;
          maxp_d   = best_val_d;
          terr_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New requests win over the clear so nothing arriving in the take cycle is lost.
    key_pend_d  = (key_pend_q & ~take) | key_tick;
    auto_pend_d = (auto_pend_q & ~take) | (frame_tick & dirty_q & AUTO_ON);
    dirty_d     = (dirty_q & ~take) | Canvas_dirty;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      fvs_sync_q  <= '0;
      key_sync_q  <= '0;
      key_pend_q  <= 1'b0;
      auto_pend_q <= 1'b0;
      dirty_q     <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      scan_q      <= '0;
      argmax_q    <= '0;
      maxp_q      <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fvs_sync_q  <= {fvs_sync_q[1:0], Frame_vs};
      key_sync_q  <= {key_sync_q[1:0], Key_req};
      key_pend_q  <= key_pend_d;
      auto_pend_q <= auto_pend_d;
      dirty_q     <= dirty_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      scan_q      <= scan_d;
      argmax_q    <= argmax_d;
      maxp_q      <= maxp_d;
      terr_q      <= terr_d;
    end
  end

  // Scan datapath carries no reset; it is always initialised by the capture.
  always_ff @(posedge Clk) begin
    best_val_q <= best_val_d;
    best_idx_q <= best_idx_d;
    if (capture) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        prob_q[i] <= Nn_prob[i*PROB_W +: PROB_W];
      end
    end
  end

  assign Nn_start     = (state_q == START);
  assign Busy         = (state_q != IDLE);
  assign Result_valid = (state_q == DONE);
  assign Argmax       = argmax_q;
  assign Max_prob     = maxp_q;
  assign Timeout_err  = terr_q;

endmodule

// File: tb/tb_nn_inference_scheduler.sv
// Directed bench for nn_inference_scheduler: a behavioural network answers each Nn_start,
// results are compared against hand-computed argmax values.
module tb_nn_inference_scheduler;

  localparam int NC = 10;
  localparam int PW = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Frame_vs = 1'b0;
  logic              Key_req = 1'b0;
  logic              Canvas_dirty = 1'b0;
  logic              Nn_ready = 1'b1;
  logic [NC*PW-1:0]  Nn_prob = '0;
  logic              Nn_start, Busy, Result_valid, Timeout_err;
  logic [3:0]        Argmax;
  logic [PW-1:0]     Max_prob;
  logic              Nn_start2, Busy2, Result_valid2, Timeout_err2;
  logic [3:0]        Argmax2;
  logic [PW-1:0]     Max_prob2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0, start_cnt2 = 0, rv_cnt = 0, rv_cyc = 0;
  int rise_cnt = 0, rise_cyc = 0;
  int net_en = 1, pre_dly = 2, busy_dly = 50;

  nn_inference_scheduler #(.NUM_CLASSES(NC), .PROB_W(PW), .TIMEOUT_CYC(100), .AUTO_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .Frame_vs(Frame_vs), .Key_req(Key_req),
    .Canvas_dirty(Canvas_dirty), .Nn_ready(Nn_ready), .Nn_prob(Nn_prob),
    .Nn_start(Nn_start), .Busy(Busy), .Argmax(Argmax), .Max_prob(Max_prob),
    .Result_valid(Result_valid), .Timeout_err(Timeout_err)
  );

  nn_inference_scheduler #(.NUM_CLASSES(NC), .PROB_W(PW), .TIMEOUT_CYC(100), .AUTO_EN(0)) dut2 (
    .Clk(Clk), .Reset(Reset), .Frame_vs(Frame_vs), .Key_req(Key_req),
    .Canvas_dirty(Canvas_dirty), .Nn_ready(Nn_ready), .Nn_prob(Nn_prob),
    .Nn_start(Nn_start2), .Busy(Busy2), .Argmax(Argmax2), .Max_prob(Max_prob2),
    .Result_valid(Result_valid2), .Timeout_err(Timeout_err2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Nn_start)  start_cnt  <= start_cnt + 1;
    if (Nn_start2) start_cnt2 <= start_cnt2 + 1;
    if (Result_valid) begin
      rv_cnt <= rv_cnt + 1;
      rv_cyc <= cyc;
    end
  end

  // Network model: drops ready pre_dly cycles after a start, raises it busy_dly cycles later.
  always begin
    @(posedge Clk); #1;
    if (Nn_start && net_en != 0) begin
      repeat (pre_dly) begin @(posedge Clk); #1; end
      Nn_ready = 1'b0;
      repeat (busy_dly) begin @(posedge Clk); #1; end
      Nn_ready = 1'b1;
      rise_cyc = cyc;
      rise_cnt = rise_cnt + 1;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic set_probs(input logic [PW-1:0] v [NC]);
    for (int i = 0; i < NC; i++) Nn_prob[i*PW +: PW] = v[i];
  endtask

  task automatic key_press();
    Key_req = 1'b1;
    ticks(4);
    Key_req = 1'b0;
  endtask

  task automatic frame_pulse();
    Frame_vs = 1'b1;
    ticks(3);
    Frame_vs = 1'b0;
    ticks(3);
  endtask

  task automatic wait_rv(input int base, input string tag);
    int n = 0;
    while (rv_cnt == base && n < 400) begin ticks(1); n++; end
    check_eq(tag, 32'(rv_cnt != base), 32'd1);
  endtask

  task automatic wait_start(input int base, input string tag);
    int n = 0;
    while (start_cnt == base && n < 100) begin ticks(1); n++; end
    check_eq(tag, 32'(start_cnt != base), 32'd1);
  endtask

  task automatic wait_rise(input int base, input string tag);
    int n = 0;
    while (rise_cnt == base && n < 200) begin ticks(1); n++; end
    check_eq(tag, 32'(rise_cnt != base), 32'd1);
  endtask

  initial begin
    logic [PW-1:0] pv [NC];
    int bs, br, bv;

    // Reset state
    ticks(3);
    check_eq("rst_busy", 32'(Busy), 0);
    check_eq("rst_start", 32'(Nn_start), 0);
    check_eq("rst_argmax", 32'(Argmax), 0);
    check_eq("rst_maxp", 32'(Max_prob), 0);
    check_eq("rst_rv", 32'(Result_valid), 0);
    check_eq("rst_terr", 32'(Timeout_err), 0);
    check_eq("rst_dut2", 32'({Busy2, Nn_start2, Argmax2, Max_prob2, Result_valid2, Timeout_err2}), 0);
    Reset = 1'b0;
    ticks(3);

    // Auto gating: frames without a dirty canvas start nothing
    pv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h9000, 16'h0700, 16'h0800, 16'h0900, 16'h0A00};
    set_probs(pv);
    repeat (3) frame_pulse();
    ticks(20);
    check_eq("auto_clean_starts", 32'(start_cnt), 0);
    Canvas_dirty = 1'b1;
    ticks(1);
    Canvas_dirty = 1'b0;
    frame_pulse();
    wait_rv(0, "auto_rv_seen");
    ticks(20);
    check_eq("auto_dirty_starts", 32'(start_cnt), 1);
    check_eq("auto_en0_starts", 32'(start_cnt2), 0);
    check_eq("auto_argmax", 32'(Argmax), 5);
    check_eq("auto_maxp", 32'(Max_prob), 32'h9000);

    // Manual run; input changes after capture must not disturb the result
    pv = '{16'h0100, 16'h0200, 16'h7F00, 16'h0010, 16'h0050, 16'h7EFF, 16'h0020, 16'h0030, 16'h0040, 16'h0001};
    set_probs(pv);
    bs = start_cnt; br = rise_cnt; bv = rv_cnt;
    key_press();
    wait_rise(br, "man_rise_seen");
    ticks(1);
    Nn_prob = '1;
    wait_rv(bv, "man_rv_seen");
    check_eq("man_latency", 32'(rv_cyc - rise_cyc), 10);
    check_eq("man_argmax", 32'(Argmax), 2);
    check_eq("man_maxp", 32'(Max_prob), 32'h7F00);
    check_eq("man_argmax_dut2", 32'(Argmax2), 2);
    ticks(20);
    check_eq("man_one_start", 32'(start_cnt - bs), 1);

    // Tie between entries 3 and 7
    pv = '{16'h1234, 16'h0001, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h8000, 16'h4000, 16'hFFFF, 16'h0002, 16'hFFFE};
    set_probs(pv);
    bv = rv_cnt;
    key_press();
    wait_rv(bv, "tie_rv_seen");
    check_eq("tie_argmax", 32'(Argmax), 3);
    check_eq("tie_maxp", 32'(Max_prob), 32'hFFFF);
    ticks(5);

    // Reset asserted mid-SCAN
    br = rise_cnt;
    key_press();
    wait_rise(br, "rstscan_rise_seen");
    ticks(4);
    check_eq("rstscan_busy_before", 32'(Busy), 1);
    Reset = 1'b1;
    #1;
    check_eq("rstscan_busy", 32'(Busy), 0);
    check_eq("rstscan_argmax", 32'(Argmax), 0);
    check_eq("rstscan_maxp", 32'(Max_prob), 0);
    check_eq("rstscan_rv_terr", 32'({Result_valid, Timeout_err, Nn_start}), 0);
    ticks(2);
    Reset = 1'b0;
    bs = start_cnt;
    ticks(30);
    check_eq("rstscan_no_start", 32'(start_cnt - bs), 0);
    check_eq("rstscan_idle", 32'(Busy), 0);

    // Stale ready through START, new requests while waiting
    pv = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070, 16'h0080, 16'h0090, 16'h8000};
    set_probs(pv);
    pre_dly = 6;
    bs = start_cnt; bv = rv_cnt;
    key_press();
    wait_start(bs, "stale_start_seen");
    Key_req = 1'b1;
    Canvas_dirty = 1'b1;
    ticks(1);
    Canvas_dirty = 1'b0;
    Frame_vs = 1'b1;
    ticks(2);
    check_eq("stale_not_taken", 32'({Busy, 1'b0} | 32'(rv_cnt - bv)), 32'h2);
    ticks(2);
    Frame_vs = 1'b0;
    Key_req = 1'b0;
    wait_rv(bv, "stale_rv_seen");
    check_eq("stale_latency", 32'(rv_cyc - rise_cyc), 10);
    check_eq("stale_argmax", 32'(Argmax), 9);
    wait_rv(bv + 1, "stale_second_rv");
    ticks(80);
    check_eq("stale_starts", 32'(start_cnt - bs), 2);
    check_eq("stale_rv_count", 32'(rv_cnt - bv), 2);

    // Timeout with the network never responding
    pre_dly = 2;
    net_en = 0;
    bs = start_cnt; bv = rv_cnt;
    key_press();
    wait_start(bs, "to_start_seen");
    ticks(94);
    check_eq("to_busy_waiting", 32'(Busy), 1);
    ticks(10);
    check_eq("to_idle", 32'(Busy), 0);
    check_eq("to_terr", 32'(Timeout_err), 1);
    check_eq("to_argmax_kept", 32'(Argmax), 9);
    check_eq("to_maxp_kept", 32'(Max_prob), 32'h8000);
    check_eq("to_no_rv", 32'(rv_cnt - bv), 0);

    // Successful run clears the error; winner at index 0
    net_en = 1;
    pv = '{16'hF000, 16'h0100, 16'hEFFF, 16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'hF000};
    set_probs(pv);
    bv = rv_cnt;
    key_press();
    wait_rv(bv, "rec_rv_seen");
    check_eq("rec_terr_cleared", 32'(Timeout_err), 0);
    check_eq("rec_argmax", 32'(Argmax), 0);
    check_eq("rec_maxp", 32'(Max_prob), 32'hF000);
    ticks(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_inference_scheduler.md
Name: nn_inference_scheduler

Overview:
- Sequences the neural_network datapath.
- Arbitrates two compute requesters:
  - manual request from the Compute key;
  - automatic request, once per VGA frame, but only when the canvas has changed.
- Issues a single-cycle start to the network and waits for its ready handshake, with a timeout.
- Latches the 10 class probabilities and runs a serial argmax over them. Presents a stable result (class, probability) to the HEX display logic.

Parameters:
- NUM_CLASSES, 10, number of probability entries scanned.
- PROB_W, 16, width of each unsigned probability.
- TIMEOUT_CYC, 2_000_000, maximum Clk cycles allowed in WAIT before abort (40 ms at 50 MHz).
- AUTO_EN, 1, 1 = frame-driven automatic requests enabled; 0 = manual only.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- Frame_vs  in  1  VGA vertical sync (pixel-clock domain, treated as asynchronous).
- Key_req  in  1  manual compute request, level from debounced key; asynchronous.
- Canvas_dirty  in  1  single-Clk pulse: canvas contents changed.
- Nn_ready  in  1  network ready level; low while computing.
- Nn_prob  in  NUM_CLASSES*PROB_W  flattened probabilities; entry i at bits [i*PROB_W +: PROB_W].
- Nn_start  out  1  single-cycle compute pulse to the network.
- Busy  out  1  high in any state other than IDLE.
- Argmax  out  4  winning class index.
- Max_prob  out  PROB_W  probability of the winning class.
- Result_valid  out  1  single-cycle pulse when Argmax/Max_prob update.
- Timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0: Nn_start, Busy, Argmax, Max_prob, Result_valid, Timeout_err.
  - Pending flags, dirty flag, counters and synchronizers cleared.
- Input conditioning:
  - Frame_vs and Key_req each pass through a 2-flop synchronizer.
  - frame_tick = rising edge of the synchronized Frame_vs.
  - key_tick = rising edge of the synchronized Key_req.
- Request capture:
  - key_tick sets key_pend.
  - Canvas_dirty sets dirty.
  - frame_tick with dirty=1 and AUTO_EN=1 sets auto_pend.
  - Flags are captured in any state, so a request arriving while Busy is served afterwards.
  - Multiple ticks collapse into one pending request.
- State machine:
  - IDLE:
    - If key_pend or auto_pend, go to START.
    - Key has priority. Taking either request clears both pend flags and dirty.
    - If Canvas_dirty arrives in the same cycle as the clear, set wins and dirty stays 1.
  - START:
    - Nn_start=1 for exactly this cycle.
    - Timeout counter cleared, ack_seen cleared; go to WAIT.
  - WAIT:
    - Counter increments every cycle.
    - Nn_ready=0 sets ack_seen.
    - Nn_ready=1 with ack_seen=1 means done:
      - capture the full Nn_prob vector into an internal register;
      - best_val = entry 0, best_idx = 0, scan_idx = 1;
      - go to SCAN.
    - Nn_ready high before ack_seen is ignored (stale ready from the previous run).
    - When the counter reaches TIMEOUT_CYC-1 without done:
      - Timeout_err = 1;
      - go to IDLE;
      - Argmax and Max_prob keep their previous values;
      - no Result_valid pulse.
  - SCAN:
    - One entry per cycle.
    - If entry[scan_idx] > best_val (unsigned, strict), update best_val and best_idx.
    - Increment scan_idx; after scan_idx = NUM_CLASSES-1, go to DONE.
    - Takes NUM_CLASSES-1 cycles.
    - Ties resolve to the lowest index.
  - DONE:
    - Argmax = best_idx, Max_prob = best_val, Result_valid = 1 for this cycle.
    - Timeout_err cleared; go to IDLE.
- Busy = (state != IDLE), registered with the state.
- Latency, from the done cycle in WAIT to the Result_valid pulse: NUM_CLASSES cycles (10 by default).
- Nn_prob changes after capture do not affect the result in progress.
- Reset asserted mid-WAIT or mid-SCAN:
  - immediate return to IDLE;
  - prior result cleared to 0;
  - no Nn_start issued until a new request arrives.

Test Plan:
- Reset check: assert Reset mid-SCAN -> in the same cycle, outputs go to 0 and state to IDLE. After release, no Nn_start without a new request.
- Manual run:
  - Stimulus: Key_req rises. Network model drops Nn_ready 2 cycles after Nn_start and raises it 50 cycles later. Nn_prob = {0x0100, 0x0200, 0x7F00, 0x0010, ...}, all other entries < 0x7F00.
  - Required: exactly one Nn_start pulse. Result_valid 10 cycles after the done cycle, with Argmax=2 and Max_prob=0x7F00.
- Tie and ordering: entries 3 and 7 both 0xFFFF, all others smaller -> Argmax=3, Max_prob=0xFFFF.
- Auto gating:
  - 3 frame_ticks with no Canvas_dirty -> no Nn_start.
  - One Canvas_dirty pulse then a frame_tick -> exactly one Nn_start.
  - With AUTO_EN=0 -> none.
- Stale ready and pending:
  - Stimulus: Nn_ready held high through START. While in WAIT, Key_req rises and Canvas_dirty plus frame_tick also occur.
  - Required: the result is not taken until a low-then-high ready. Afterwards, exactly one further Nn_start is issued.
- Timeout:
  - Stimulus: TIMEOUT_CYC=100; Nn_ready is never dropped.
  - Required: return to IDLE 100 cycles after START, Timeout_err=1, previous Argmax retained, no Result_valid.
  - A subsequent successful run clears Timeout_err in its DONE cycle.
